weight_load_control_unit: RTL and testbench
===========================================

// Module: weight_load_control_unit
// PURPOSE
//  Producer side of the compute weight handshake. Fetches MUL_SIZE x MUL_SIZE weight tiles from weight memory
//  and writes them row by row into the MAC array's two ping-pong shadow weight buffers. Raises
//  compute_weights_rdy_o for the compute control unit and frees a buffer on its next_weight_tile pulse.
//  Sits between the instruction decoder / weight memory and the MAC array weight registers.
// PARAMETERS
//  MUL_SIZE  32  MAC array dimension (rows per tile, weights per row)
//  DATA_W    8   weight element width
//  ADDR_W    16  weight memory row-address width
// PORTS
//  clk_i                clk  1                  clock, all state on rising edge
//  rst_i                in   1                  asynchronous, active-low reset
//  start_i              in   1                  load-op request (MAC_op[1]), sampled in IDLE only
//  U_dim_i              in   8                  matrix U dimension; tile count = U_dim_i >> 5 (1..7)
//  weight_base_addr_i   in   ADDR_W             row address of tile 0, row 0
//  next_weight_tile_i   in   1                  compute side has finished the active buffer
//  weight_mem_rd_en_o   out  1                  weight memory read strobe
//  weight_mem_addr_o    out  ADDR_W             weight memory row address
//  weight_mem_data_i    in   MUL_SIZE*DATA_W    read data, valid exactly 1 cycle after rd_en
//  weight_row_wr_en_o   out  1                  shadow weight row write strobe
//  weight_row_sel_o     out  $clog2(MUL_SIZE)   row being written
//  weight_buf_sel_o     out  1                  shadow buffer being written (0/1)
//  weight_row_data_o    out  MUL_SIZE*DATA_W    row data (registered copy of weight_mem_data_i)
//  compute_weights_rdy_o out 1                  buffer selected for compute holds a complete tile
//  busy_o               out  1                  high in every state except IDLE
//  done_o               out  1                  1-cycle pulse: last tile released by compute side
// BEHAVIOUR
//  Reset (rst_i=0, async): state IDLE; all outputs 0; full_q=2'b00; wr_buf_q=0; rd_buf_q=0; counters 0.
//  State: full_q[1:0] per buffer; wr_buf_q = buffer being filled; rd_buf_q = buffer used by compute.
//  compute_weights_rdy_o = full_q[rd_buf_q] (registered state, no comb path from inputs).
//  IDLE: on start_i with (U_dim_i>>5)!=0 -> latch tiles/base, tile_q=0, row_q=0, go FETCH.
//    start_i with tile count 0 is ignored (stay IDLE). start_i outside IDLE is ignored.
//  FETCH: if full_q[wr_buf_q]=0: rd_en=1, addr = base + tile_q*MUL_SIZE + row_q (mod 2^ADDR_W), row_q++.
//    Otherwise rd_en=0 and row_q holds (stall; no partial-tile overwrite of a full buffer).
//    Write stage 1 cycle later: wr_en=1, row_sel = delayed row_q, buf_sel = wr_buf_q, data = mem data.
//    After last row write (row MUL_SIZE-1) commits: full_q[wr_buf_q]<=1, wr_buf_q toggles, tile_q++.
//    Tile load = MUL_SIZE rd cycles; rdy rises MUL_SIZE+2 cycles after first rd_en if buffer empty.
//    When tile_q reaches tile count after commit -> DRAIN; else next tile (stall while target full).
//  DRAIN: no reads; wait until full_q==2'b00 after releases, then done_o pulse (1 cycle), go IDLE.
//  Release: next_weight_tile_i while rdy=1 -> full_q[rd_buf_q]<=0, rd_buf_q toggles. Ignored if rdy=0.
//  Simultaneous commit and release same cycle: both apply (different buffers); if same buffer,
//    release clears, then commit sets -> commit wins (buffer is refilled).
//  Max 2 tiles resident; fetch of tile n+2 never starts before tile n released.
//  Reset mid-operation: aborts any fetch, drops pending write stage, clears full_q; no done_o.
// TESTING
//  1 tile: U_dim=32, base=0x100, start -> rd_en 32 cyc addr 0x100..0x11F; rdy=1 at cycle 34; release -> done_o 1 cyc later.
//  2 tiles, no release: U_dim=64 -> both buffers filled (buf_sel 0 then 1), tile 1 addr 0x120.., rdy stays 1, no further reads.
//  3 tiles backpressure: U_dim=96, hold next_weight_tile_i=0 -> rd_en stops after 64 rows; release -> tile 2 into buf 0.
//  Simultaneous: release pulse on exact cycle tile 1 commits -> full_q=2'b10, rd_buf=1, rdy stays 1.
//  Illegal/ignored: start with U_dim=16 -> stays IDLE, busy_o=0; next_weight_tile_i while rdy=0 -> no state change.
//  Reset mid-fetch at row 10 -> all outputs 0 immediately; new start reloads from row 0 of tile 0.

Source files
------------

// File: rtl/weight_load_control_unit_if.sv
// Weight memory read port and MAC-array shadow weight row write port.
// master = weight load control unit, slave = memory / MAC array side.
interface weight_load_control_unit_if #(
    parameter int unsigned MUL_SIZE = 32,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 16
);
    localparam int unsigned ROW_W = $clog2(MUL_SIZE);

    logic                         weight_mem_rd_en_o;
    logic [ADDR_W-1:0]            weight_mem_addr_o;
    logic [MUL_SIZE*DATA_W-1:0]   weight_mem_data_i;
    logic                         weight_row_wr_en_o;
    logic [ROW_W-1:0]             weight_row_sel_o;
    logic                         weight_buf_sel_o;
    logic [MUL_SIZE*DATA_W-1:0]   weight_row_data_o;

    modport master (
        output weight_mem_rd_en_o,
        output weight_mem_addr_o,
        input  weight_mem_data_i,
        output weight_row_wr_en_o,
        output weight_row_sel_o,
        output weight_buf_sel_o,
        output weight_row_data_o
    );

    modport slave (
        input  weight_mem_rd_en_o,
        input  weight_mem_addr_o,
        output weight_mem_data_i,
        input  weight_row_wr_en_o,
        input  weight_row_sel_o,
        input  weight_buf_sel_o,
        input  weight_row_data_o
    );
endinterface

// File: rtl/weight_load_control_unit.sv
// Fetches weight tiles row by row from weight memory into two ping-pong shadow
// buffers and hands each complete buffer to the compute side.
module weight_load_control_unit #(
    parameter int unsigned MUL_SIZE = 32,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [7:0]              U_dim_i,
    input  logic [ADDR_W-1:0]       weight_base_addr_i,
    input  logic                    next_weight_tile_i,
    weight_load_control_unit_if.master bus,
    output logic                    compute_weights_rdy_o,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int unsigned ROW_W = $clog2(MUL_SIZE);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MUL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e                     state_q;
    logic [1:0]                 full_q, full_nxt;
    logic                       wr_buf_q, rd_buf_q;
    logic [7:0]                 tiles_q, tile_q, tiles_in;
    logic [ADDR_W-1:0]          base_q, addr_q;
    logic [ROW_W-1:0]           row_q, rd_row_q, data_row_q, row_sel_q;
    logic                       issued_q, rd_en_q, data_vld_q, wr_en_q, buf_sel_q, done_q;
    logic [MUL_SIZE*DATA_W-1:0] row_data_q;
    logic                       rel_now, commit_now;

    assign tiles_in = U_dim_i >> ROW_W;

    // Release clears the compute buffer first so a same-buffer commit wins.
    always_comb begin
        rel_now    = next_weight_tile_i && full_q[rd_buf_q];
        commit_now = wr_en_q && (row_sel_q == LAST_ROW);
        full_nxt   = full_q;
        if (rel_now)    full_nxt[rd_buf_q]  = 1'b0;
        if (commit_now) full_nxt[buf_sel_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            full_q     <= '0;
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b0;
            tiles_q    <= '0;
            tile_q     <= '0;
            base_q     <= '0;
            row_q      <= '0;
            issued_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            rd_row_q   <= '0;
            data_vld_q <= 1'b0;
            data_row_q <= '0;
            wr_en_q    <= 1'b0;
            row_sel_q  <= '0;
            buf_sel_q  <= 1'b0;
            row_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            full_q     <= full_nxt;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            // Read issue -> data returned -> row write, one register per stage.
            data_vld_q <= rd_en_q;
            data_row_q <= rd_row_q;
            wr_en_q    <= data_vld_q;
            if (data_vld_q) begin
                row_sel_q  <= data_row_q;
                buf_sel_q  <= wr_buf_q;
                row_data_q <= bus.weight_mem_data_i;
            end
            if (rel_now) rd_buf_q <= ~rd_buf_q;
            if (commit_now) begin
                wr_buf_q <= ~wr_buf_q;
                tile_q   <= tile_q + 8'd1;
                issued_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start_i && tiles_in != 8'd0) begin
                        tiles_q  <= tiles_in;
                        base_q   <= weight_base_addr_i;
                        tile_q   <= '0;
                        row_q    <= '0;
                        issued_q <= 1'b0;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    if (commit_now && (tile_q + 8'd1 == tiles_q)) begin
                        state_q <= DRAIN;
                    end else if (!issued_q && !full_q[wr_buf_q]) begin
                        rd_en_q  <= 1'b1;
                        addr_q   <= base_q + ADDR_W'(tile_q) * ADDR_W'(MUL_SIZE) + ADDR_W'(row_q);
                        rd_row_q <= row_q;
                        if (row_q == LAST_ROW) begin
                            row_q    <= '0;
                            issued_q <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (full_nxt == 2'b00) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.weight_mem_rd_en_o = rd_en_q;
    assign bus.weight_mem_addr_o  = addr_q;
    assign bus.weight_row_wr_en_o = wr_en_q;
    assign bus.weight_row_sel_o   = row_sel_q;
    assign bus.weight_buf_sel_o   = buf_sel_q;
    assign bus.weight_row_data_o  = row_data_q;
    assign compute_weights_rdy_o  = full_q[rd_buf_q];
    assign busy_o                 = (state_q != IDLE);
    assign done_o                 = done_q;
endmodule

// File: tb/tb_weight_load_control_unit.sv
// Bench for weight_load_control_unit: tile-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized operations.
module tb_weight_load_control_unit;
    localparam int M = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        next_tile = 1'b0;
    logic [7:0]  udim = '0;
    logic [15:0] base = '0;
    logic        rdy, busy, done;
    int          checks = 0;
    int          failures = 0;

    weight_load_control_unit_if #(.MUL_SIZE(32), .DATA_W(8), .ADDR_W(16)) bus ();

    weight_load_control_unit #(.MUL_SIZE(32), .DATA_W(8), .ADDR_W(16)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_n),
        .start_i               (start),
        .U_dim_i               (udim),
        .weight_base_addr_i    (base),
        .next_weight_tile_i    (next_tile),
        .bus                   (bus),
        .compute_weights_rdy_o (rdy),
        .busy_o                (busy),
        .done_o                (done)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mem_word(input logic [15:0] a);
        logic [255:0] w;
        for (int i = 0; i < 8; i++)
            w[i*32 +: 32] = ({a, 16'(i)} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
        return w;
    endfunction

    // Weight memory: data for a read appears one cycle after rd_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.weight_mem_data_i <= '0;
        else if (bus.weight_mem_rd_en_o) bus.weight_mem_data_i <= mem_word(bus.weight_mem_addr_o);
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference model: counts of rows issued, tiles committed and tiles released.
    // A new tile may start only after the previous one committed and while fewer
    // than two tiles are resident; each read lands as a row write two cycles later.
    typedef struct { int due; int row; bit bsel; logic [15:0] addr; } wr_t;
    wr_t         wq[$];
    int          cyc = 0;
    bit          m_active = 0, m_wbuf = 0, m_last_pend = 0;
    int          m_tiles = 0, m_issued = 0, m_committed = 0, m_released = 0;
    logic [15:0] m_base = '0;
    bit          exp_rd = 0, exp_wr = 0, exp_buf = 0, exp_rdy = 0, exp_busy = 0, exp_done = 0;
    logic [15:0] exp_addr = '0;
    logic [4:0]  exp_row = '0;
    logic [255:0] exp_data = '0;
    int          com_old, t, r;
    bit          rel, com, iss;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq.delete();
            m_active = 0; m_wbuf = 0; m_last_pend = 0;
            m_tiles = 0; m_issued = 0; m_committed = 0; m_released = 0;
            exp_rd = 0; exp_wr = 0; exp_rdy = 0; exp_busy = 0; exp_done = 0;
        end else begin
            com_old = m_committed;
            rel = next_tile && (m_committed > m_released);
            com = m_last_pend;
            iss = m_active && (m_committed < m_tiles) &&
                  (((m_issued % M) != 0) ||
                   (m_issued == m_committed * M && (m_committed - m_released) < 2));
            exp_rd = 0; exp_wr = 0; exp_done = 0; m_last_pend = 0;
            if (iss) begin
                t = m_issued / M;
                r = m_issued % M;
                exp_rd = 1;
                exp_addr = m_base + 16'(t * M + r);
                wq.push_back('{cyc + 2, r, m_wbuf, exp_addr});
                m_issued++;
            end
            if (wq.size() > 0 && wq[0].due == cyc) begin
                exp_wr = 1;
                exp_row = 5'(wq[0].row);
                exp_buf = wq[0].bsel;
                exp_data = mem_word(wq[0].addr);
                m_last_pend = (wq[0].row == M - 1);
                void'(wq.pop_front());
            end
            if (com) begin m_committed++; m_wbuf = !m_wbuf; end
            if (rel) m_released++;
            if (!m_active) begin
                if (start && (udim >> 5) != 0) begin
                    m_active = 1; m_tiles = int'(udim >> 5); m_base = base;
                    m_issued = 0; m_committed = 0; m_released = 0;
                end
            end else if (com_old == m_tiles && m_committed == m_released) begin
                exp_done = 1;
                m_active = 0;
            end
            exp_rdy = m_committed > m_released;
            exp_busy = m_active;
            cyc++;
        end
    end

    always @(negedge clk) begin
        chk("rd_en", bus.weight_mem_rd_en_o, exp_rd);
        if (exp_rd) chk("rd_addr", bus.weight_mem_addr_o, exp_addr);
        chk("wr_en", bus.weight_row_wr_en_o, exp_wr);
        if (exp_wr) begin
            chk("row_sel", bus.weight_row_sel_o, exp_row);
            chk("buf_sel", bus.weight_buf_sel_o, exp_buf);
            chk("row_data", bus.weight_row_data_o, exp_data);
        end
        chk("rdy", rdy, exp_rdy);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_start(input logic [7:0] u, input logic [15:0] b);
        udim = u; base = b; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int n_rd, n2, nw0, first_k, rdy_k, k2, first_wb, last_wb, guard, rst_at;
    logic [15:0] first_a, last_a, a33;
    bit got;

    initial begin
        #1;
        rst_n = 1'b0;
        step();
        chk("reset_busy", busy, 0);
        chk("reset_rdy", rdy, 0);
        chk("reset_rd_en", bus.weight_mem_rd_en_o, 0);
        chk("reset_wr_en", bus.weight_row_wr_en_o, 0);
        step();
        rst_n = 1'b1;
        step();

        // One tile: 32 reads from 0x100, rdy 34 cycles after the first read.
        pulse_start(8'd32, 16'h0100);
        n_rd = 0; first_k = -1; rdy_k = -1; first_a = '0; last_a = '0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bus.weight_mem_rd_en_o) begin
                if (first_k < 0) begin first_k = k; first_a = bus.weight_mem_addr_o; end
                last_a = bus.weight_mem_addr_o;
                n_rd++;
            end
            if (rdy && rdy_k < 0) rdy_k = k;
        end
        chk("t1_rd_count", n_rd, 32);
        chk("t1_first_addr", first_a, 16'h0100);
        chk("t1_last_addr", last_a, 16'h011F);
        chk("t1_rdy_latency", rdy_k - first_k, 34);
        next_tile = 1'b1; step(); next_tile = 1'b0;
        chk("t1_done", done, 1);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);

        // Two tiles, never released.
        do_reset();
        pulse_start(8'd64, 16'h0100);
        n_rd = 0; a33 = '0; first_wb = -1; last_wb = -1;
        for (int k = 0; k < 120; k++) begin
            step();
            if (bus.weight_mem_rd_en_o) begin
                if (n_rd == 32) a33 = bus.weight_mem_addr_o;
                n_rd++;
            end
            if (bus.weight_row_wr_en_o) begin
                if (first_wb < 0) first_wb = int'(bus.weight_buf_sel_o);
                last_wb = int'(bus.weight_buf_sel_o);
            end
        end
        chk("t2_rd_count", n_rd, 64);
        chk("t2_tile1_addr", a33, 16'h0120);
        chk("t2_first_buf", first_wb, 0);
        chk("t2_last_buf", last_wb, 1);
        chk("t2_rdy", rdy, 1);
        chk("t2_busy", busy, 1);

        // Three tiles with backpressure, then one release lets tile 2 into buffer 0.
        do_reset();
        pulse_start(8'd96, 16'h0100);
        n_rd = 0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (bus.weight_mem_rd_en_o) n_rd++;
        end
        chk("t3_stall_count", n_rd, 64);
        chk("t3_rdy", rdy, 1);
        next_tile = 1'b1; step(); next_tile = 1'b0;
        n2 = 0; nw0 = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bus.weight_mem_rd_en_o) n2++;
            if (bus.weight_row_wr_en_o && bus.weight_buf_sel_o == 1'b0) nw0++;
        end
        chk("t3_tile2_reads", n2, 32);
        chk("t3_tile2_buf0_writes", nw0, 32);

        // Release on the exact cycle tile 1 commits.
        do_reset();
        pulse_start(8'd64, 16'h0000);
        k2 = 0;
        for (int k = 0; k < 150 && k2 < 2; k++) begin
            step();
            if (bus.weight_row_wr_en_o && bus.weight_row_sel_o == 5'd31) k2++;
        end
        chk("sim_reach_commit", k2, 2);
        next_tile = 1'b1; step(); next_tile = 1'b0;
        chk("sim_rdy", rdy, 1);
        chk("sim_busy", busy, 1);
        chk("sim_no_done", done, 0);
        next_tile = 1'b1; step(); next_tile = 1'b0;
        chk("sim_done", done, 1);

        // Ignored requests.
        do_reset();
        pulse_start(8'd16, 16'h0040);
        step();
        chk("ill_busy", busy, 0);
        next_tile = 1'b1; step(); next_tile = 1'b0;
        chk("ill_rdy", rdy, 0);
        chk("ill_busy2", busy, 0);

        // Reset in the middle of a fetch, then restart from row 0 of tile 0.
        do_reset();
        pulse_start(8'd32, 16'h0300);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            step();
            if (bus.weight_mem_rd_en_o && bus.weight_mem_addr_o == 16'h030A) got = 1;
        end
        chk("mid_reach_row10", got, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rd_en", bus.weight_mem_rd_en_o, 0);
        chk("mid_addr", bus.weight_mem_addr_o, 0);
        chk("mid_wr_en", bus.weight_row_wr_en_o, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rdy", rdy, 0);
        step();
        rst_n = 1'b1;
        step();
        pulse_start(8'd32, 16'h0300);
        step();
        chk("mid_restart_rd", bus.weight_mem_rd_en_o, 1);
        chk("mid_restart_addr", bus.weight_mem_addr_o, 16'h0300);

        // Randomized operations with random releases and occasional resets.
        do_reset();
        for (int op = 0; op < 25; op++) begin
            pulse_start(8'($urandom_range(0, 255)), 16'($urandom));
            guard = 0;
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 150)) : -1;
            while (busy && guard < 3000) begin
                next_tile = ($urandom_range(0, 5) == 0);
                start = (guard < 20) && ($urandom_range(0, 7) == 0);
                if (start) begin udim = 8'($urandom); base = 16'($urandom); end
                if (guard == rst_at) begin
                    rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                end
                step();
                guard++;
            end
            start = 1'b0;
            next_tile = 1'b0;
            chk("op_timeout", guard < 3000, 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
